// File: rtl/ahb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_ctrl
// Description : AHB-Lite slave in front of a synchronous single-port SRAM.
//               Writes go through a one-entry write buffer. The buffer
//               drains on any cycle without a read issue. Reads are issued in
//               the address phase and return after RD_WAIT extra cycles.
//               Data still in the buffer is forwarded into read data.
//               Illegal transfers get a two-cycle ERROR response.
// Ports       : sys_root_clk/sys_root_rst - clock, sync active-high reset
//               hsel..hwdata              - AHB-Lite slave inputs
//               hreadyout/hresp/hrdata    - AHB-Lite slave outputs
//               sram_*                    - SRAM port (rdata valid 1 cycle
//                                           after a read issue)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_ctrl #(
    parameter int AW        = 15,
    parameter int MEM_BYTES = 32768,
    parameter int RD_WAIT   = 0
) (
    input  logic          sys_root_clk,
    input  logic          sys_root_rst,
    input  logic          hsel,
    input  logic          hready,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic          hwrite,
    input  logic [AW-1:0] haddr,
    input  logic [31:0]   hwdata,
    output logic          hreadyout,
    output logic [1:0]    hresp,
    output logic [31:0]   hrdata,
    output logic [AW-3:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic [3:0]    sram_wen,
    output logic          sram_cs,
    input  logic [31:0]   sram_rdata
);

    localparam logic [2:0]  c_st_idle   = 3'd0;
    localparam logic [2:0]  c_st_write  = 3'd1;
    localparam logic [2:0]  c_st_read   = 3'd2;
    localparam logic [2:0]  c_st_err1   = 3'd3;
    localparam logic [2:0]  c_st_err2   = 3'd4;
    localparam logic [AW:0] c_mem_limit = (AW+1)'(MEM_BYTES);
    localparam logic [1:0]  c_rd_wait   = 2'(RD_WAIT);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          w_hreadyout;
    logic          w_err_resp;
    logic          w_accept;
    logic          w_err;
    logic          w_rd_req;
    logic          w_rd_issue;
    logic          w_wr_accept;
    logic          w_err_accept;
    logic          w_drain;
    logic          w_buf_load;
    logic          w_fwd_hit;
    logic [3:0]    w_mask;
    logic [31:0]   w_merged;
    logic [AW-3:0] w_word;
    logic [AW-3:0] r_wa_addr;
    logic [3:0]    r_wa_mask;
    logic [AW-3:0] r_rd_addr;
    logic [1:0]    r_rd_cnt;
    logic          r_rd_first;
    logic [31:0]   r_rdata_q;
    logic          r_buf_valid;
    logic [AW-3:0] r_buf_addr;
    logic [3:0]    r_buf_mask;
    logic [31:0]   r_buf_data;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    assign w_word = haddr[AW-1:2];

    always_comb begin
        w_mask = 4'b0000;
        case (hsize)
            3'd0:    w_mask = 4'b0001 << haddr[1:0];
            3'd1:    w_mask = haddr[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    assign w_err = ({1'b0, haddr} >= c_mem_limit)
                 | (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    // Reset gates acceptance so nothing reaches the SRAM in a reset cycle.
    assign w_accept     = hsel & hready & htrans[1] & ~sys_root_rst;
    // Read request without hready: used for the write stall so that
    // hreadyout never depends on hready (no combinational loop).
    assign w_rd_req     = hsel & htrans[1] & ~hwrite & ~w_err;
    assign w_rd_issue   = w_accept & ~hwrite & ~w_err;
    assign w_wr_accept  = w_accept & hwrite & ~w_err;
    assign w_err_accept = w_accept & w_err;

    // Buffer drains whenever the SRAM port is not taken by a read.
    assign w_drain    = r_buf_valid & ~w_rd_issue & ~sys_root_rst;
    assign w_buf_load = (r_state == c_st_write) & w_hreadyout;

    // ------------------------------------------------------------------
    // Data-phase state machine
    // ------------------------------------------------------------------
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_hreadyout) begin
            if (w_err_accept) begin
                w_next_state = c_st_err1;
            end else if (w_wr_accept) begin
                w_next_state = c_st_write;
            end else if (w_rd_issue) begin
                w_next_state = c_st_read;
            end else begin
                w_next_state = c_st_idle;
            end
        end else if (r_state == c_st_err1) begin
            w_next_state = c_st_err2;
        end
    end

    always_comb begin
        w_hreadyout = 1'b1;
        w_err_resp  = 1'b0;
        case (r_state)
            c_st_err1: begin
                w_hreadyout = 1'b0;
                w_err_resp  = 1'b1;
            end
            c_st_err2:  w_err_resp  = 1'b1;
            c_st_read:  w_hreadyout = (r_rd_cnt == 2'd0);
            // Old entry cannot drain while a read wants the port: stall
            // one cycle; hready then drops, the read waits and we drain.
            c_st_write: w_hreadyout = ~(r_buf_valid & w_rd_req);
            default:    w_hreadyout = 1'b1;
        endcase
    end

    assign hreadyout = w_hreadyout;
    assign hresp     = {1'b0, w_err_resp};

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            r_rd_cnt    <= 2'd0;
            r_rd_first  <= 1'b0;
            r_rdata_q   <= 32'd0;
            r_buf_valid <= 1'b0;
        end else begin
            r_rd_first <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_cnt <= c_rd_wait;
            end else if ((r_state == c_st_read) && (r_rd_cnt != 2'd0)) begin
                r_rd_cnt <= r_rd_cnt - 2'd1;
            end
            if (r_rd_first) begin
                r_rdata_q <= w_merged;
            end
            if (w_buf_load) begin
                r_buf_valid <= 1'b1;
            end else if (w_drain) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    // Datapath registers qualified by the control state above.
    always_ff @(posedge sys_root_clk) begin
        if (w_wr_accept) begin
            r_wa_addr <= w_word;
            r_wa_mask <= w_mask;
        end
        if (w_rd_issue) begin
            r_rd_addr <= w_word;
        end
        if (w_buf_load) begin
            r_buf_addr <= r_wa_addr;
            r_buf_mask <= r_wa_mask;
            r_buf_data <= hwdata;
        end
    end

    // ------------------------------------------------------------------
    // Read data: buffered bytes override stale SRAM lanes
    // ------------------------------------------------------------------
    assign w_fwd_hit = r_buf_valid & (r_buf_addr == r_rd_addr);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = (w_fwd_hit & r_buf_mask[gi]) ?
                                     r_buf_data[8*gi +: 8] : sram_rdata[8*gi +: 8];
    end

    assign hrdata = r_rd_first ? w_merged : r_rdata_q;

    // ------------------------------------------------------------------
    // SRAM port: read issue has priority over buffer drain
    // ------------------------------------------------------------------
    always_comb begin
        sram_cs    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = r_buf_addr;
        sram_wdata = r_buf_data;
        if (w_rd_issue) begin
            sram_cs   = 1'b1;
            sram_addr = w_word;
        end else if (w_drain) begin
            sram_cs  = 1'b1;
            sram_wen = r_buf_mask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_ctrl
// Description : Directed bench for ahb_sram_ctrl. Instance 1 uses defaults
//               and runs a cycle-by-cycle vector table. Instance 2 uses
//               MEM_BYTES=16384 and RD_WAIT=2 for wait-state and
//               out-of-range cases. Each instance has a behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_ctrl;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, hsel, hwrite, tb_init;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [14:0] haddr;
    logic [31:0] hwdata;

    logic        rdy1, rdy2, cs1, cs2;
    logic [1:0]  resp1, resp2;
    logic [31:0] hrdata1, hrdata2, swdata1, swdata2, srdata1, srdata2;
    logic [12:0] saddr1, saddr2;
    logic [3:0]  wen1, wen2;

    logic [31:0] mem1 [0:8191];
    logic [31:0] mem2 [0:4095];

    int n_vec = 0;
    int n_err = 0;

    ahb_sram_ctrl u_dut1 (
        .sys_root_clk(clk), .sys_root_rst(rst), .hsel(hsel), .hready(rdy1),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .haddr(haddr),
        .hwdata(hwdata), .hreadyout(rdy1), .hresp(resp1), .hrdata(hrdata1),
        .sram_addr(saddr1), .sram_wdata(swdata1), .sram_wen(wen1),
        .sram_cs(cs1), .sram_rdata(srdata1)
    );

    ahb_sram_ctrl #(.AW(15), .MEM_BYTES(16384), .RD_WAIT(2)) u_dut2 (
        .sys_root_clk(clk), .sys_root_rst(rst), .hsel(hsel), .hready(rdy2),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .haddr(haddr),
        .hwdata(hwdata), .hreadyout(rdy2), .hresp(resp2), .hrdata(hrdata2),
        .sram_addr(saddr2), .sram_wdata(swdata2), .sram_wen(wen2),
        .sram_cs(cs2), .sram_rdata(srdata2)
    );

    // Behavioural synchronous SRAMs
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 8192; i++) mem1[i] <= 32'hC0DE_0000 | 32'(i);
            mem1[4] <= 32'h1122_3344;
        end else if (cs1) begin
            if (wen1 == 4'b0000) srdata1 <= mem1[saddr1];
            else for (int i = 0; i < 4; i++)
                if (wen1[i]) mem1[saddr1][8*i +: 8] <= swdata1[8*i +: 8];
        end
    end

    always @(posedge clk) begin
        if (tb_init) begin
            for (int j = 0; j < 4096; j++) mem2[j] <= 32'hB0B0_0000 | 32'(j);
        end else if (cs2) begin
            if (wen2 == 4'b0000) srdata2 <= mem2[saddr2[11:0]];
            else for (int j = 0; j < 4; j++)
                if (wen2[j]) mem2[saddr2[11:0]][8*j +: 8] <= swdata2[8*j +: 8];
        end
    end

    typedef struct {
        logic        rst, sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic        e_cs;
        logic [3:0]  e_wen;
        logic [12:0] e_saddr;
        logic [31:0] e_swdata;
        logic        c_rd;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic s, input logic [1:0] t,
                               input logic w, input logic [2:0] sz, input logic [14:0] a,
                               input logic [31:0] wd, input logic er, input logic [1:0] ep,
                               input logic ec, input logic [3:0] ew, input logic [12:0] ea,
                               input logic [31:0] ewd, input logic cr, input logic [31:0] erd);
        vec_t x;
        x.rst = r; x.sel = s; x.trans = t; x.wr = w; x.size = sz; x.addr = a;
        x.wdata = wd; x.e_rdy = er; x.e_resp = ep; x.e_cs = ec; x.e_wen = ew;
        x.e_saddr = ea; x.e_swdata = ewd; x.c_rd = cr; x.e_rdata = erd;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] t, input logic w,
                         input logic [2:0] sz, input logic [14:0] a, input logic [31:0] wd);
        @(negedge clk);
        rst = r; hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a; hwdata = wd;
        #2;
    endtask

    initial begin
        rst = 1'b1; tb_init = 1'b1; hsel = 1'b0; htrans = ID; hwrite = 1'b0;
        hsize = 3'd0; haddr = '0; hwdata = '0;

        //                r s trans w size addr      wdata          rdy resp cs wen  saddr swdata      chk rdata
        // reset state
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        1,32'h0));
        // byte write 0x13 then immediate read of 0x10: forwarded byte 3
        vecs.push_back(v(0,1,NS,1,3'd0,15'h0013,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,NS,0,3'd2,15'h0010,32'h77AABBCC, 1,2'd0,1,4'h0,13'd4, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,1,4'h8,13'd4, 32'h77AABBCC, 1,32'h77223344));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        1,32'h77223344));
        // word write 0x10, drain next cycle
        vecs.push_back(v(0,1,NS,1,3'd2,15'h0010,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'hA5A51234, 1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,1,4'hF,13'd4, 32'hA5A51234, 1,32'h77223344));
        // halfword write 0x2, then misaligned word write 0x2 -> ERROR
        vecs.push_back(v(0,1,NS,1,3'd1,15'h0002,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,NS,1,3'd2,15'h0002,32'hBEEF0000, 1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        0,2'd1,1,4'hC,13'd0, 32'hBEEF0000, 0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd1,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        // hsize=3 read -> ERROR, read 0x24 pipelined in the second error cycle
        vecs.push_back(v(0,1,NS,0,3'd3,15'h0020,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        0,2'd1,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,NS,0,3'd2,15'h0024,32'h0,        1,2'd1,1,4'h0,13'd9, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        1,32'hC0DE0009));
        // W 0x30, W 0x34, R 0x30: second write data phase stalls one cycle
        vecs.push_back(v(0,1,NS,1,3'd2,15'h0030,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,NS,1,3'd2,15'h0034,32'h11111111, 1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,NS,0,3'd2,15'h0030,32'h22222222, 0,2'd0,1,4'hF,13'd12,32'h11111111, 0,32'h0));
        vecs.push_back(v(0,1,NS,0,3'd2,15'h0030,32'h22222222, 1,2'd0,1,4'h0,13'd12,32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,1,4'hF,13'd13,32'h22222222, 1,32'h11111111));
        vecs.push_back(v(0,1,NS,0,3'd2,15'h0034,32'h0,        1,2'd0,1,4'h0,13'd13,32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        1,32'h22222222));
        // unselected NONSEQ and BUSY are ignored
        vecs.push_back(v(0,0,NS,1,3'd2,15'h0040,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,BZ,1,3'd2,15'h0040,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h99999999, 1,2'd0,0,4'h0,13'd0, 32'h0,        1,32'h22222222));
        // buffered write 0x50 discarded by a one-cycle reset
        vecs.push_back(v(0,1,NS,1,3'd2,15'h0050,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'hDEADBEEF, 1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(1,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        1,32'h0));
        vecs.push_back(v(0,1,NS,0,3'd2,15'h0050,32'h0,        1,2'd0,1,4'h0,13'd20,32'h0,        0,32'h0));
        vecs.push_back(v(0,1,ID,0,3'd0,15'h0000,32'h0,        1,2'd0,0,4'h0,13'd0, 32'h0,        1,32'hC0DE0014));

        repeat (2) @(posedge clk);
        @(negedge clk);
        tb_init = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].sel, vecs[k].trans, vecs[k].wr,
                  vecs[k].size, vecs[k].addr, vecs[k].wdata);
            check($sformatf("v%0d hreadyout", k), 32'(rdy1),  32'(vecs[k].e_rdy));
            check($sformatf("v%0d hresp", k),     32'(resp1), 32'(vecs[k].e_resp));
            check($sformatf("v%0d sram_cs", k),   32'(cs1),   32'(vecs[k].e_cs));
            check($sformatf("v%0d sram_wen", k),  32'(wen1),  32'(vecs[k].e_wen));
            if (vecs[k].e_cs)
                check($sformatf("v%0d sram_addr", k), 32'(saddr1), 32'(vecs[k].e_saddr));
            if (vecs[k].e_wen != 4'h0)
                check($sformatf("v%0d sram_wdata", k), swdata1, vecs[k].e_swdata);
            if (vecs[k].c_rd)
                check($sformatf("v%0d hrdata", k), hrdata1, vecs[k].e_rdata);
        end

        // Instance 2: RD_WAIT=2, MEM_BYTES=16384
        drive(1, 0, ID, 0, 3'd0, 15'h0, 32'h0);
        drive(1, 0, ID, 0, 3'd0, 15'h0, 32'h0);
        drive(0, 1, NS, 0, 3'd2, 15'h0020, 32'h0);
        check("w2 issue hreadyout", 32'(rdy2),  32'd1);
        check("w2 issue sram_cs",   32'(cs2),   32'd1);
        check("w2 issue sram_addr", 32'(saddr2), 32'd8);
        check("w2 issue sram_wen",  32'(wen2),  32'd0);
        drive(0, 1, ID, 0, 3'd0, 15'h0, 32'h0);
        check("w2 wait1 hreadyout", 32'(rdy2),  32'd0);
        check("w2 wait1 hrdata",    hrdata2,    32'hB0B00008);
        drive(0, 1, ID, 0, 3'd0, 15'h0, 32'h0);
        check("w2 wait2 hreadyout", 32'(rdy2),  32'd0);
        check("w2 wait2 hrdata",    hrdata2,    32'hB0B00008);
        drive(0, 1, ID, 0, 3'd0, 15'h0, 32'h0);
        check("w2 last hreadyout",  32'(rdy2),  32'd1);
        check("w2 last hresp",      32'(resp2), 32'd0);
        check("w2 last hrdata",     hrdata2,    32'hB0B00008);

        drive(0, 1, NS, 0, 3'd2, 15'h4000, 32'h0);
        check("oor addr hreadyout", 32'(rdy2),  32'd1);
        check("oor addr sram_cs",   32'(cs2),   32'd0);
        drive(0, 1, ID, 0, 3'd0, 15'h0, 32'h0);
        check("oor err1 hreadyout", 32'(rdy2),  32'd0);
        check("oor err1 hresp",     32'(resp2), 32'd1);
        check("oor err1 sram_cs",   32'(cs2),   32'd0);
        drive(0, 1, ID, 0, 3'd0, 15'h0, 32'h0);
        check("oor err2 hreadyout", 32'(rdy2),  32'd1);
        check("oor err2 hresp",     32'(resp2), 32'd1);
        check("oor err2 sram_cs",   32'(cs2),   32'd0);
        drive(0, 1, ID, 0, 3'd0, 15'h0, 32'h0);
        check("oor after hresp",    32'(resp2), 32'd0);
        check("oor after hreadyout",32'(rdy2),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
